// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// controller states, access size codes and small decode helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_t;

  // A half must sit on an even address and a word on a 4-byte boundary;
  // the reserved size code can never be performed.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane;
      default: return 1'b1;
    endcase
  endfunction

  // Byte enables for a store of the given size starting at byte lane 'lane'.
  function automatic logic [3:0] store_strobe(input size_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: picks the addressed byte/half out of the bus word
// and zero- or sign-extends it to a full 32-bit register value.
module load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then widen it according to size
  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    data    = rdata;
    case (size)
      SZ_B:    data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller. Turns decoder load/store requests
// into valid/ready bus transactions, stalls the pipeline while one is in
// flight, and reports misaligned accesses, bus errors and timeouts.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic        i_isLoadSigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_flush,
  output logic        o_busReq,
  output logic        o_busWrite,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWdata,
  output logic [3:0]  o_busStrb,
  input  logic        i_busReady,
  input  logic [31:0] i_busRdata,
  input  logic        i_busErr,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdataValid,
  output logic        o_misaligned,
  output logic        o_accessFault
);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  size_t            req_size;
  size_t            lat_size;
  logic [1:0]       lat_lane;
  logic             lat_signed;
  logic             killed;
  logic             kill_now;
  logic             req_mis;
  logic             can_accept;
  logic             accept;
  logic             timeout_hit;
  logic [31:0]      aligned_rdata;
  logic             unused_funct3_msb;

  // Only the low two funct3 bits carry the size; signedness arrives separately.
  assign unused_funct3_msb = i_funct3[2];
  assign req_size          = size_t'(i_funct3[1:0]);
  assign req_mis           = is_misaligned(req_size, i_addr[1:0]);

  // A new access can start from IDLE or straight out of DONE (no bubble).
  assign can_accept   = (state != ST_BUSY);
  assign accept       = ~i_rst & can_accept & i_memReq & ~i_flush & ~req_mis;
  assign o_misaligned = ~i_rst & can_accept & i_memReq & ~i_flush & req_mis;
  assign o_stall      = accept | (state == ST_BUSY);

  // A flush seen in any BUSY cycle, including the completing one, kills the result.
  assign kill_now    = killed | i_flush;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  load_align u_load_align (
    .rdata     (i_busRdata),
    .lane      (lat_lane),
    .size      (lat_size),
    .is_signed (lat_signed),
    .data      (aligned_rdata)
  );

  // Controller FSM: latches the request, holds the bus until ready or timeout,
  // and produces the one-cycle completion pulses in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      lat_size      <= SZ_B;
      lat_lane      <= 2'b00;
      lat_signed    <= 1'b0;
      killed        <= 1'b0;
      o_busReq      <= 1'b0;
      o_busWrite    <= 1'b0;
      o_busAddr     <= '0;
      o_busWdata    <= '0;
      o_busStrb     <= '0;
      o_rdata       <= '0;
      o_rdataValid  <= 1'b0;
      o_accessFault <= 1'b0;
    end else begin
      o_rdataValid  <= 1'b0;
      o_accessFault <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state      <= ST_BUSY;
            wait_cnt   <= '0;
            killed     <= 1'b0;
            lat_size   <= req_size;
            lat_lane   <= i_addr[1:0];
            lat_signed <= i_isLoadSigned;
            o_busReq   <= 1'b1;
            o_busWrite <= i_memWrite;
            o_busAddr  <= {i_addr[31:2], 2'b00};
            o_busWdata <= i_wdata << {i_addr[1:0], 3'b000};
            o_busStrb  <= i_memWrite ? store_strobe(req_size, i_addr[1:0]) : 4'b0000;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          killed <= kill_now;
          if (i_busReady) begin
            state         <= ST_DONE;
            o_busReq      <= 1'b0;
            o_rdataValid  <= ~o_busWrite & ~i_busErr & ~kill_now;
            o_accessFault <= i_busErr & ~kill_now;
            if (!o_busWrite) begin
              o_rdata <= aligned_rdata;
            end
          end else if (timeout_hit) begin
            state         <= ST_DONE;
            o_busReq      <= 1'b0;
            o_accessFault <= ~kill_now;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_busReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
